// File: rtl/cordic_phase_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cordic_arb_pkg
//  Description : Shared constants, FSM encoding and round-robin search helper
//                for the CORDIC phase arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_arb_pkg;

    // +pi in 1.2.13 signed fixed point
    localparam logic signed [15:0] PI_Q13 = 16'sh6488;

    // Largest requester count the search helper supports
    localparam int MAX_REQ = 8;

    typedef enum logic [0:0] {
        ST_DRAIN = 1'b0,
        ST_RUN   = 1'b1
    } arb_state_e;

    // First set bit of valid at or above start (wrapping modulo n); -1 if none
    function automatic int rr_search(input logic [MAX_REQ-1:0] valid,
                                     input logic [2:0]         start,
                                     input int                 n);
        int         pick;
        logic [2:0] idx;
        pick = -1;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = 3'((int'(start) + k) % n);
            if ((k < n) && (pick < 0) && valid[idx]) begin
                pick = int'(idx);
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_phase_arbiter_tag_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tag_fifo
//  Description : Synchronous first-word-fall-through FIFO holding requester
//                tags of phases in flight through the CORDIC core.
//  Revision    : 1.0 - initial release
// ============================================================================
module tag_fifo #(
    parameter int TAG_W = 2,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [TAG_W-1:0]         i_push_tag,
    input  logic                     i_pop,
    output logic [TAG_W-1:0]         o_pop_tag,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    // Storage array; contents need no reset since the count gates reads
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_tag;
        end
    end

    // Pointers and occupancy; push and pop together leave the level unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_pop_tag = r_mem[r_rd_ptr];
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;

endmodule
`default_nettype wire

// File: rtl/cordic_phase_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cordic_phase_arbiter
//  Description : Round-robin sharing of one sin/cos CORDIC core between
//                N_REQ phase requesters, with tag-based result steering,
//                phase range clamping and a post-reset drain window.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_phase_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 16,
    parameter int LATENCY    = 20,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                     aclk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_phase,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     phase_valid,
    output logic [WIDTH-1:0]         phase,
    input  logic                     sin_cos_valid,
    input  logic [WIDTH-1:0]         sin,
    input  logic [WIDTH-1:0]         cos,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]         rsp_sin,
    output logic [WIDTH-1:0]         rsp_cos,
    output logic                     err_range,
    output logic                     err_orphan
);

    localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(LATENCY + 1);

    localparam logic [CNT_W-1:0]        c_DRAIN_LOAD = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0]        c_DRAIN_LAST = CNT_W'(1);
    localparam logic [LVL_W-1:0]        c_FULL_LVL   = LVL_W'(FIFO_DEPTH);
    localparam logic [TAG_W-1:0]        c_LAST_REQ   = TAG_W'(N_REQ - 1);
    localparam logic signed [WIDTH-1:0] c_PI_POS     = WIDTH'(PI_Q13);
    localparam logic signed [WIDTH-1:0] c_PI_NEG     = -c_PI_POS;

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    logic [CNT_W-1:0]        r_drain_cnt;
    logic                    w_run;
    logic [TAG_W-1:0]        r_rr;
    int                      w_pick;
    logic [TAG_W-1:0]        w_winner;
    logic [N_REQ-1:0]        w_ready;
    logic                    w_accept;
    logic                    w_room;
    logic                    w_pop;
    logic                    w_orphan;
    logic signed [WIDTH-1:0] w_phase_arr [N_REQ];
    logic signed [WIDTH-1:0] w_sel_phase;
    logic signed [WIDTH-1:0] w_clamped;
    logic                    w_out_of_range;
    logic [TAG_W-1:0]        w_pop_tag;
    logic                    w_fifo_empty;
    logic [LVL_W-1:0]        w_fifo_level;
    logic                    r_phase_valid;
    logic [WIDTH-1:0]        r_phase;
    logic [N_REQ-1:0]        r_rsp_valid;
    logic [WIDTH-1:0]        r_rsp_sin;
    logic [WIDTH-1:0]        r_rsp_cos;
    logic                    r_err_range;
    logic                    r_err_orphan;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_phase_unpack
            assign w_phase_arr[gi] = req_phase[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // FSM state register
    always_ff @(posedge aclk) begin
        if (reset) r_state <= ST_DRAIN;
        else       r_state <= w_state_nxt;
    end

    // FSM next state: leave DRAIN once the in-flight window has elapsed
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_DRAIN: if (r_drain_cnt <= c_DRAIN_LAST) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_DRAIN;
        endcase
    end

    // FSM outputs; nothing is granted or popped while reset is held
    always_comb begin
        w_run = (r_state == ST_RUN) && !reset;
    end

    // Drain counter covers the core latency so stale results are discarded
    always_ff @(posedge aclk) begin
        if (reset)                            r_drain_cnt <= c_DRAIN_LOAD;
        else if (!w_run && r_drain_cnt != '0) r_drain_cnt <= r_drain_cnt - 1'b1;
    end

    // Result return and orphan detection; a pop frees a slot this same cycle
    always_comb begin
        w_pop    = w_run && sin_cos_valid && !w_fifo_empty;
        w_orphan = w_run && sin_cos_valid &&  w_fifo_empty;
        w_room   = (w_fifo_level != c_FULL_LVL) || w_pop;
    end

    // Round-robin pick and one-hot grant, gated by RUN and tag FIFO room
    always_comb begin
        w_pick   = rr_search(MAX_REQ'(req_valid), 3'(r_rr), N_REQ);
        w_winner = TAG_W'(w_pick);
        w_ready  = '0;
        if (w_run && (w_pick >= 0) && w_room) begin
            w_ready[w_winner] = 1'b1;
        end
        w_accept = |w_ready;
    end

    // Clamp the winning phase into [-pi, +pi]
    always_comb begin
        w_sel_phase    = w_phase_arr[w_winner];
        w_clamped      = w_sel_phase;
        w_out_of_range = 1'b0;
        if (w_sel_phase > c_PI_POS) begin
            w_clamped      = c_PI_POS;
            w_out_of_range = 1'b1;
        end else if (w_sel_phase < c_PI_NEG) begin
            w_clamped      = c_PI_NEG;
            w_out_of_range = 1'b1;
        end
    end

    // Issue register toward the core; phase holds when idle
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_phase_valid <= 1'b0;
            r_phase       <= '0;
        end else begin
            r_phase_valid <= w_accept;
            if (w_accept) r_phase <= w_clamped;
        end
    end

    // Round-robin pointer moves past the requester just served
    always_ff @(posedge aclk) begin
        if (reset)         r_rr <= '0;
        else if (w_accept) r_rr <= (w_winner == c_LAST_REQ) ? '0 : w_winner + 1'b1;
    end

    // Response register steers core data to the tagged requester
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_rsp_valid <= '0;
            r_rsp_sin   <= '0;
            r_rsp_cos   <= '0;
        end else begin
            r_rsp_valid <= w_pop ? (N_REQ'(1) << w_pop_tag) : '0;
            if (w_pop) begin
                r_rsp_sin <= sin;
                r_rsp_cos <= cos;
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_err_range  <= 1'b0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_accept && w_out_of_range) r_err_range  <= 1'b1;
            if (w_orphan)                   r_err_orphan <= 1'b1;
        end
    end

    tag_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk        (aclk),
        .rst        (reset),
        .i_push     (w_accept),
        .i_push_tag (w_winner),
        .i_pop      (w_pop),
        .o_pop_tag  (w_pop_tag),
        .o_empty    (w_fifo_empty),
        .o_level    (w_fifo_level)
    );

    assign req_ready   = w_ready;
    assign phase_valid = r_phase_valid;
    assign phase       = r_phase;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_sin     = r_rsp_sin;
    assign rsp_cos     = r_rsp_cos;
    assign err_range   = r_err_range;
    assign err_orphan  = r_err_orphan;

endmodule
`default_nettype wire

// File: tb/tb_cordic_phase_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_phase_arbiter
//  Description : Randomized self-checking bench; the core is a queue-based
//                delay line (sin=phase, cos=~phase) that can be stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_phase_arbiter;

    localparam int N_REQ      = 4;
    localparam int WIDTH      = 16;
    localparam int LATENCY    = 20;
    localparam int FIFO_DEPTH = 32;
    localparam int PI_INT     = 25736;  // 0x6488

    logic                   aclk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_phase;
    logic [N_REQ-1:0]       req_ready;
    logic                   phase_valid;
    logic [WIDTH-1:0]       phase;
    logic                   sin_cos_valid;
    logic [WIDTH-1:0]       sin;
    logic [WIDTH-1:0]       cos;
    logic [N_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]       rsp_sin;
    logic [WIDTH-1:0]       rsp_cos;
    logic                   err_range;
    logic                   err_orphan;

    always #5 aclk = ~aclk;

    cordic_phase_arbiter #(
        .N_REQ      (N_REQ),
        .WIDTH      (WIDTH),
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .aclk          (aclk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_phase     (req_phase),
        .req_ready     (req_ready),
        .phase_valid   (phase_valid),
        .phase         (phase),
        .sin_cos_valid (sin_cos_valid),
        .sin           (sin),
        .cos           (cos),
        .rsp_valid     (rsp_valid),
        .rsp_sin       (rsp_sin),
        .rsp_cos       (rsp_cos),
        .err_range     (err_range),
        .err_orphan    (err_orphan)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester side
    bit [N_REQ-1:0]   pend;
    logic [WIDTH-1:0] pph [N_REQ];
    bit [N_REQ-1:0]   req_mask = '0;
    int               req_pct  = 0;
    bit               fix_en   = 0;
    logic [WIDTH-1:0] fix_ph   = '0;
    bit               oor_en   = 0;

    // Core model
    logic [WIDTH-1:0] core_ph  [$];
    int               core_due [$];
    bit               stall  = 0;
    bit               inject = 0;

    // Reference model of the arbiter
    int               tq_tag [$];
    logic [WIDTH-1:0] tq_ph  [$];
    int               tq_at  [$];
    int               m_rr = 0;
    int               m_since = 0;
    int               cyc = 0;
    int               last_grant = -1;
    int               n_rsp_seen = 0;
    bit               lat_chk = 0;
    bit               lat_pend = 0;
    int               lat_at = 0;
    logic             exp_phase_valid = 0;
    logic [WIDTH-1:0] exp_phase = '0;
    logic [N_REQ-1:0] exp_rsp_valid = '0;
    logic [WIDTH-1:0] exp_sin = '0;
    logic [WIDTH-1:0] exp_cos = '0;
    logic             exp_err_range = 0;
    logic             exp_err_orphan = 0;

    function automatic logic [WIDTH-1:0] rand_phase();
        int v;
        if (oor_en && ($urandom_range(3) == 0)) return WIDTH'($urandom);
        v = int'($urandom_range(2 * PI_INT)) - PI_INT;
        return WIDTH'(v);
    endfunction

    function automatic int as_signed(input logic [WIDTH-1:0] x);
        return (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
    endfunction

    // One clock cycle: drive, check the grant, advance the model, check outputs
    task automatic step();
        int               pick;
        int               v;
        int               t;
        bit               run;
        bit               room;
        bit               pop;
        bit               core_out;
        logic [WIDTH-1:0] cl;
        logic [WIDTH-1:0] ph;
        logic [N_REQ-1:0] exp_ready;
        @(negedge aclk);
        for (int i = 0; i < N_REQ; i++) begin
            if (!pend[i] && req_mask[i] && (int'($urandom_range(99)) < req_pct)) begin
                pend[i] = 1'b1;
                pph[i]  = fix_en ? fix_ph : rand_phase();
            end
            req_valid[i]                = pend[i];
            req_phase[i*WIDTH +: WIDTH] = pph[i];
        end
        core_out = 1'b0;
        if (!stall && core_due.size() > 0) core_out = (core_due[0] <= cyc);
        if (core_out) begin
            sin_cos_valid = 1'b1;
            sin           = core_ph[0];
            cos           = ~core_ph[0];
        end else begin
            sin_cos_valid = inject;
            sin           = WIDTH'($urandom);
            cos           = WIDTH'($urandom);
        end
        #1;
        run  = !reset && (m_since >= LATENCY);
        pop  = run && sin_cos_valid && (tq_tag.size() > 0);
        room = (tq_tag.size() < FIFO_DEPTH) || pop;
        pick = -1;
        if (run && room) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (pick < 0 && pend[(m_rr + k) % N_REQ]) pick = (m_rr + k) % N_REQ;
            end
        end
        exp_ready = (pick >= 0) ? N_REQ'(1 << pick) : '0;
        chk("req_ready", req_ready, exp_ready);
        last_grant = pick;

        exp_rsp_valid = '0;
        if (pop) begin
            t  = tq_tag.pop_front();
            ph = tq_ph.pop_front();
            lat_at = tq_at.pop_front();
            lat_pend = lat_chk;
            chk("core_data", sin, ph);
            exp_rsp_valid = N_REQ'(1 << t);
            exp_sin = sin;
            exp_cos = cos;
        end
        if (run && sin_cos_valid && tq_tag.size() == 0 && !pop) exp_err_orphan = 1'b1;
        if (pick >= 0) begin
            v  = as_signed(pph[pick]);
            cl = pph[pick];
            if (v > PI_INT)  begin cl = WIDTH'(PI_INT);  exp_err_range = 1'b1; end
            if (v < -PI_INT) begin cl = WIDTH'(-PI_INT); exp_err_range = 1'b1; end
            tq_tag.push_back(pick);
            tq_ph.push_back(cl);
            tq_at.push_back(cyc);
            exp_phase_valid = 1'b1;
            exp_phase = cl;
            pend[pick] = 1'b0;
            m_rr = (pick + 1) % N_REQ;
        end else begin
            exp_phase_valid = 1'b0;
        end
        if (core_out) begin
            void'(core_ph.pop_front());
            void'(core_due.pop_front());
        end
        if (reset) begin
            tq_tag.delete(); tq_ph.delete(); tq_at.delete();
            m_rr = 0; m_since = 0; lat_pend = 0;
            exp_phase_valid = 0; exp_phase = '0; exp_rsp_valid = '0;
            exp_sin = '0; exp_cos = '0; exp_err_range = 0; exp_err_orphan = 0;
        end else begin
            m_since++;
        end

        @(posedge aclk);
        #1;
        cyc++;
        if (rsp_valid !== '0) n_rsp_seen++;
        chk("phase_valid", phase_valid, exp_phase_valid);
        chk("phase", phase, exp_phase);
        chk("rsp_valid", rsp_valid, exp_rsp_valid);
        chk("rsp_sin", rsp_sin, exp_sin);
        chk("rsp_cos", rsp_cos, exp_cos);
        chk("err_range", err_range, exp_err_range);
        chk("err_orphan", err_orphan, exp_err_orphan);
        if (lat_pend) begin
            chk("latency", cyc - lat_at, LATENCY + 2);
            lat_pend = 0;
        end
        if (phase_valid === 1'b1) begin
            core_ph.push_back(phase);
            core_due.push_back(cyc + LATENCY);
        end
    endtask

    task automatic idle(input int n);
        req_mask = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Single-requester clamp check for requester 2
    task automatic range_case(input logic [WIDTH-1:0] in_ph, input logic [WIDTH-1:0] out_ph, input string tag);
        int guard;
        fix_en = 1; fix_ph = in_ph; req_pct = 100; req_mask = 4'b0100;
        guard = 0;
        step();
        while (pend[2] && guard < 10) begin step(); guard++; end
        req_mask = '0;
        chk({tag, "_accept"}, pend[2], 1'b0);
        chk({tag, "_phase"}, phase, out_ph);
        chk({tag, "_err"}, err_range, 1'b1);
        fix_en = 0;
    endtask

    initial begin
        int g;
        int guard;
        reset = 1'b1;
        sin_cos_valid = 1'b0;
        sin = '0;
        cos = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pend[i] = 1'b1;
            pph[i]  = rand_phase();
            req_valid[i] = 1'b1;
            req_phase[i*WIDTH +: WIDTH] = pph[i];
        end
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_phase_valid", phase_valid, 1'b0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_err", {err_range, err_orphan}, 2'b00);

        // Drain window with every requester valid, then grants in rr order
        reset = 1'b0;
        req_mask = '1; req_pct = 100; lat_chk = 1;
        for (int i = 0; i < LATENCY; i++) begin
            step();
            chk("drain_no_grant", last_grant, -1);
        end
        step();
        chk("first_grant", last_grant, 0);
        g = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            chk("rr_order", last_grant, g % N_REQ);
            g++;
        end
        idle(30);

        // Range clamping on requester 2
        chk("err_range_clear", err_range, 1'b0);
        range_case(16'h7000, 16'h6488, "clamp_hi");
        idle(25);
        range_case(16'h9000, 16'h9B78, "clamp_lo");
        idle(25);

        // Random traffic
        oor_en = 1; req_mask = '1; req_pct = 40;
        for (int i = 0; i < 300; i++) step();
        idle(30);

        // Orphan result with nothing outstanding
        chk("orphan_pre", err_orphan, 1'b0);
        inject = 1; step(); inject = 0;
        step();
        chk("orphan_set", err_orphan, 1'b1);

        // Stalled core: FIFO fills to its depth and grants stop until a pop
        lat_chk = 0; stall = 1; req_mask = '1; req_pct = 100;
        for (int i = 0; i < FIFO_DEPTH + 10; i++) step();
        chk("full_stall_ready", req_ready, '0);
        stall = 0; req_mask = '0;
        step();
        chk("resume_on_pop", last_grant >= 0, 1'b1);
        idle(FIFO_DEPTH + LATENCY + 20);

        // Reset with three results still in flight
        lat_chk = 0;
        pend = 4'b0111;
        guard = 0;
        while (pend != '0 && guard < 10) begin step(); guard++; end
        chk("three_accepts", pend, '0);
        idle(5);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        n_rsp_seen = 0;
        idle(LATENCY + 20);
        chk("stale_rsp", n_rsp_seen, 0);
        chk("no_orphan_drain", err_orphan, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
